// File: rtl/sdrc_stub_pkg.sv
// sdrc_stub_pkg: shared states, default sizing and address wrap helper for the SDRAM user-port responder.
package sdrc_stub_pkg;
  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_WRITE,
    ST_READ,
    ST_RECOVER,
    ST_LOWPOWER
  } state_t;
  localparam int DEF_RD_LAT      = 4;
  localparam int DEF_INIT_CYCLES = 16;
  localparam int DEF_MEM_AW      = 10;
  function automatic logic [31:0] wrap_addr(input logic [31:0] base, input logic [31:0] k, input int aw);
    return (base + k) & ((32'd1 << aw) - 32'd1);
  endfunction
endpackage

// File: rtl/sdrc_stub_ram.sv
// sdrc_stub_ram: single-port synchronous RAM with byte write enables and one-cycle read latency.
module sdrc_stub_ram #(
  parameter int DW = 32,
  parameter int AW = 10
) (
  input  logic            clk,
  input  logic [DW/8-1:0] we,
  input  logic [AW-1:0]   addr,
  input  logic [DW-1:0]   wdata,
  output logic [DW-1:0]   rdata
);
  logic [DW-1:0] mem [2**AW];
  always_ff @(posedge clk) begin
    for (int i = 0; i < DW/8; i++)
      if (we[i]) mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
    rdata <= mem[addr];
  end
endmodule

// File: rtl/sdrc_user_port_responder.sv
// sdrc_user_port_responder: cycle-accurate stand-in for the SDRAM controller user port,
// answering write/read bursts from an on-chip RAM.
module sdrc_user_port_responder
  import sdrc_stub_pkg::*;
#(
  parameter int ADDR_WIDTH  = 21,
  parameter int DATA_WIDTH  = 32,
  parameter int LEN_WIDTH   = 8,
  parameter int MEM_AW      = DEF_MEM_AW,
  parameter int RD_LAT      = DEF_RD_LAT,
  parameter int INIT_CYCLES = DEF_INIT_CYCLES
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    sdrc_wr_n,
  input  logic                    sdrc_rd_n,
  input  logic [ADDR_WIDTH-1:0]   sdrc_addr,
  input  logic [LEN_WIDTH-1:0]    sdrc_data_len,
  input  logic [DATA_WIDTH-1:0]   sdrc_data,
  input  logic [DATA_WIDTH/8-1:0] sdrc_dqm,
  input  logic                    sdrc_selfrefresh,
  input  logic                    sdrc_power_down,
  output logic                    sdrc_init_done,
  output logic                    sdrc_busy_n,
  output logic                    sdrc_wrd_ack,
  output logic                    sdrc_rd_valid,
  output logic [DATA_WIDTH-1:0]   sdrc_data_out,
  output logic                    protocol_err
);
  localparam int NB = DATA_WIDTH / 8;
  localparam int CW = LEN_WIDTH + $clog2(RD_LAT + 1) + 1;
  localparam int IW = $clog2(INIT_CYCLES + 1);
  localparam int PS = RD_LAT - 1;

  state_t                state;
  logic [IW-1:0]         init_cnt;
  logic [CW-1:0]         cnt;
  logic [MEM_AW-1:0]     base;
  logic [LEN_WIDTH-1:0]  len;
  logic                  wr, rd, accept, acc_wr, acc_rd, rd_issue, vq;
  logic [31:0]           wa;
  logic [MEM_AW-1:0]     ram_addr;
  logic [NB-1:0]         ram_we;
  logic [DATA_WIDTH-1:0] ram_q;
  logic [PS-1:0]         pv;
  logic [DATA_WIDTH-1:0] pd [PS];
  logic                  unused_bits;

  // Word 0 of a burst is addressed straight from the command so it lands in the accept cycle.
  always_comb begin
    wr       = !sdrc_wr_n;
    rd       = !sdrc_rd_n;
    accept   = state == ST_IDLE && sdrc_busy_n && (wr || rd);
    acc_wr   = accept && wr;
    acc_rd   = accept && rd && !wr;
    wa       = wrap_addr(32'(state == ST_IDLE ? sdrc_addr[MEM_AW-1:0] : base),
                         state == ST_IDLE ? 32'd0 : 32'(cnt), MEM_AW);
    ram_addr = wa[MEM_AW-1:0];
    ram_we   = (acc_wr || state == ST_WRITE) ? ~sdrc_dqm : '0;
    rd_issue = acc_rd || (state == ST_READ && cnt <= CW'(len));
  end

  assign unused_bits = ^{sdrc_addr[ADDR_WIDTH-1:MEM_AW], wa[31:MEM_AW]};

  sdrc_stub_ram #(.DW(DATA_WIDTH), .AW(MEM_AW)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (sdrc_data),
    .rdata (ram_q)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= ST_INIT;
      init_cnt       <= '0;
      cnt            <= '0;
      base           <= '0;
      len            <= '0;
      sdrc_init_done <= 1'b0;
      sdrc_busy_n    <= 1'b0;
      sdrc_wrd_ack   <= 1'b0;
      protocol_err   <= 1'b0;
    end else begin
      sdrc_wrd_ack <= accept;
      if ((wr || rd) && (!sdrc_busy_n || (wr && rd))) protocol_err <= 1'b1;
      case (state)
        ST_INIT: begin
          init_cnt <= init_cnt + 1'b1;
          if (init_cnt == IW'(INIT_CYCLES - 1)) begin
            sdrc_init_done <= 1'b1;
            sdrc_busy_n    <= 1'b1;
            state          <= ST_IDLE;
          end
        end
        ST_IDLE: begin
          if (accept) begin
            base        <= sdrc_addr[MEM_AW-1:0];
            len         <= sdrc_data_len;
            cnt         <= CW'(1);
            sdrc_busy_n <= 1'b0;
            state       <= acc_wr ? (sdrc_data_len == '0 ? ST_RECOVER : ST_WRITE) : ST_READ;
          end else if (sdrc_selfrefresh || sdrc_power_down) begin
            sdrc_busy_n <= 1'b0;
            state       <= ST_LOWPOWER;
          end
        end
        ST_WRITE: begin
          cnt <= cnt + 1'b1;
          if (cnt == CW'(len)) state <= ST_RECOVER;
        end
        ST_READ: begin
          cnt <= cnt + 1'b1;
          if (cnt == CW'(len) + CW'(RD_LAT)) state <= ST_RECOVER;
        end
        ST_RECOVER: begin
          sdrc_busy_n <= 1'b1;
          state       <= ST_IDLE;
        end
        ST_LOWPOWER: if (!sdrc_selfrefresh && !sdrc_power_down) state <= ST_RECOVER;
        default: state <= ST_INIT;
      endcase
    end
  end

  // Valid travels beside the RAM output; stages load only on valid so data_out holds between bursts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vq <= 1'b0;
      pv <= '0;
      for (int i = 0; i < PS; i++) pd[i] <= '0;
    end else begin
      vq    <= rd_issue;
      pv[0] <= vq;
      if (vq) pd[0] <= ram_q;
      for (int i = 1; i < PS; i++) begin
        pv[i] <= pv[i-1];
        if (pv[i-1]) pd[i] <= pd[i-1];
      end
    end
  end

  assign sdrc_rd_valid = pv[PS-1];
  assign sdrc_data_out = pd[PS-1];
endmodule

// File: tb/tb_sdrc_user_port_responder.sv
// tb_sdrc_user_port_responder: self-checking bench with a word-level memory model,
// a byte-mask vector table, directed corner sequences and randomized bursts.
module tb_sdrc_user_port_responder;
  localparam int AW = 21, DW = 32, LW = 8, MAW = 10, RDL = 4, INIT = 16;
  localparam int MSZ = 1 << MAW;

  logic          clk = 1'b0, rst = 1'b1;
  logic          wr_n = 1'b1, rd_n = 1'b1, selfrefresh = 1'b0, power_down = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [LW-1:0] data_len = '0;
  logic [DW-1:0] data = '0;
  logic [3:0]    dqm = '0;
  logic          init_done, busy_n, wrd_ack, rd_valid, perr;
  logic [DW-1:0] data_out;

  sdrc_user_port_responder dut (
    .clk(clk), .rst(rst), .sdrc_wr_n(wr_n), .sdrc_rd_n(rd_n), .sdrc_addr(addr),
    .sdrc_data_len(data_len), .sdrc_data(data), .sdrc_dqm(dqm),
    .sdrc_selfrefresh(selfrefresh), .sdrc_power_down(power_down),
    .sdrc_init_done(init_done), .sdrc_busy_n(busy_n), .sdrc_wrd_ack(wrd_ack),
    .sdrc_rd_valid(rd_valid), .sdrc_data_out(data_out), .protocol_err(perr)
  );

  always #5 clk = ~clk;

  int          checks = 0, errors = 0;
  logic [31:0] model [MSZ];
  bit          mvalid [MSZ];
  bit          exp_err = 1'b0;
  logic [31:0] wbuf [256];

  typedef struct {
    logic [31:0] w1;
    logic [31:0] w2;
    logic [3:0]  dqm;
    logic [31:0] exp;
  } mask_vec_t;
  mask_vec_t tbl [5];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, got, exp);
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (busy_n !== 1'b1 && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("ready", busy_n, 1);
  endtask

  task automatic do_reset(input bit strobe_in_init);
    @(negedge clk);
    rst = 1'b1; wr_n = 1'b1; rd_n = 1'b1; selfrefresh = 1'b0; power_down = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_init_done", init_done, 0);
    chk("rst_busy_n", busy_n, 0);
    chk("rst_wrd_ack", wrd_ack, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_data_out", data_out, 0);
    chk("rst_perr", perr, 0);
    rst = 1'b0;
    exp_err = strobe_in_init;
    for (int i = 1; i <= INIT; i++) begin
      if (strobe_in_init && i == 5) rd_n = 1'b0;
      if (strobe_in_init && i == 8) wr_n = 1'b0;
      @(negedge clk);
      rd_n = 1'b1; wr_n = 1'b1;
      chk("init_done_timing", init_done, i == INIT);
      chk("init_busy_timing", busy_n, i == INIT);
    end
    chk("init_wrd_ack", wrd_ack, 0);
    chk("init_perr", perr, exp_err);
  endtask

  task automatic model_write(input int a, input logic [31:0] d, input logic [3:0] m);
    if (m == 4'b0000) begin
      model[a] = d;
      mvalid[a] = 1'b1;
    end else if (mvalid[a]) begin
      for (int b = 0; b < 4; b++) if (!m[b]) model[a][8*b +: 8] = d[8*b +: 8];
    end
  endtask

  task automatic do_write(input logic [AW-1:0] a0, input int len, input logic [3:0] m, input bit both);
    wait_ready();
    for (int k = 0; k <= len; k++) begin
      wr_n = (k != 0); rd_n = !(both && k == 0);
      addr = a0; data_len = LW'(len); data = wbuf[k]; dqm = m;
      model_write((int'(a0[MAW-1:0]) + k) % MSZ, wbuf[k], m);
      @(negedge clk);
      if (k == 0) begin
        chk("wr_ack", wrd_ack, 1);
        chk("wr_busy", busy_n, 0);
      end
      chk("wr_no_rd_valid", rd_valid, 0);
    end
    wr_n = 1'b1; rd_n = 1'b1; dqm = '0;
    if (both) exp_err = 1'b1;
    chk("wr_busy_tail", busy_n, 0);
    @(negedge clk);
    chk("wr_busy_back", busy_n, 1);
  endtask

  task automatic do_read(input logic [AW-1:0] a0, input int len);
    wait_ready();
    rd_n = 1'b0; addr = a0; data_len = LW'(len);
    @(negedge clk);
    rd_n = 1'b1;
    chk("rd_ack", wrd_ack, 1);
    for (int c = 1; c <= RDL + len + 2; c++) begin
      bit expv;
      int a;
      if (c > 1) @(negedge clk);
      expv = (c >= RDL && c <= RDL + len);
      chk("rd_valid", rd_valid, expv);
      a = (int'(a0[MAW-1:0]) + c - RDL) % MSZ;
      if (expv && mvalid[a]) chk("rd_data", data_out, model[a]);
      a = (int'(a0[MAW-1:0]) + len) % MSZ;
      if (c == RDL + len + 1 && mvalid[a]) chk("rd_hold", data_out, model[a]);
      chk("rd_busy", busy_n, c == RDL + len + 2);
    end
    chk("rd_perr", perr, exp_err);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{32'hAABBCCDD, 32'h11223344, 4'b0101, 32'h11BB33DD};
    tbl[1] = '{32'h00000000, 32'hFFFFFFFF, 4'b1111, 32'h00000000};
    tbl[2] = '{32'h12345678, 32'h9ABCDEF0, 4'b0000, 32'h9ABCDEF0};
    tbl[3] = '{32'hCAFEBABE, 32'h00000000, 4'b1000, 32'hCA000000};
    tbl[4] = '{32'hDEADBEEF, 32'h01234567, 4'b0110, 32'h01ADBE67};
    for (int i = 0; i < MSZ; i++) mvalid[i] = 1'b0;

    do_reset(1'b1);
    do_reset(1'b0);

    for (int k = 0; k <= 25; k++) wbuf[k] = k;
    do_write(21'h2_0105, 25, 4'b0000, 1'b0);
    do_read(21'h2_0105, 25);
    chk("basic_last_word", data_out, 25);

    for (int i = 0; i < 5; i++) begin
      wbuf[0] = tbl[i].w1;
      do_write(AW'(21'h100 + i), 0, 4'b0000, 1'b0);
      wbuf[0] = tbl[i].w2;
      do_write(AW'(21'h100 + i), 0, tbl[i].dqm, 1'b0);
      do_read(AW'(21'h100 + i), 0);
      chk("mask_table", data_out, tbl[i].exp);
    end

    for (int k = 0; k < 4; k++) wbuf[k] = 32'hA0 + k;
    do_write(21'h0_03FE, 3, 4'b0000, 1'b0);
    do_read(21'h1_C3FE, 3);
    do_read(21'h0_0000, 1);
    chk("wrap_low_word", data_out, 32'hA3);

    wbuf[0] = 32'h5555_0001;
    do_write(21'h200, 0, 4'b0000, 1'b0);
    do_read(21'h200, 0);
    chk("b2b_read", data_out, 32'h5555_0001);

    wait_ready();
    wr_n = 1'b0; addr = 21'h201; data_len = '0; data = 32'h77; dqm = '0;
    model_write(32'h201, 32'h77, 4'b0000);
    @(negedge clk);
    wr_n = 1'b1; rd_n = 1'b0;
    chk("early_wr_ack", wrd_ack, 1);
    chk("early_busy", busy_n, 0);
    @(negedge clk);
    rd_n = 1'b1; exp_err = 1'b1;
    chk("early_perr", perr, 1);
    chk("early_busy_back", busy_n, 1);
    chk("early_no_ack", wrd_ack, 0);
    for (int i = 0; i < RDL + 2; i++) begin
      @(negedge clk);
      chk("early_ignored_ack", wrd_ack, 0);
      chk("early_ignored_valid", rd_valid, 0);
    end
    do_read(21'h201, 0);

    wbuf[0] = 32'h0BAD_F00D;
    do_write(21'h202, 0, 4'b0000, 1'b1);
    chk("both_perr", perr, 1);
    do_read(21'h202, 0);
    chk("both_data", data_out, 32'h0BAD_F00D);

    wait_ready();
    selfrefresh = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      chk("lp_busy", busy_n, 0);
    end
    selfrefresh = 1'b0;
    begin
      int n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (busy_n !== 1'b1 && n < 2);
    end
    chk("lp_exit", busy_n, 1);
    do_read(21'h2_0105, 25);
    wait_ready();
    power_down = 1'b1;
    repeat (5) @(negedge clk);
    chk("pd_busy", busy_n, 0);
    power_down = 1'b0;
    repeat (2) @(negedge clk);
    chk("pd_exit", busy_n, 1);

    for (int it = 0; it < 40; it++) begin
      logic [AW-1:0] ra;
      int            rl;
      logic [3:0]    rm;
      ra = AW'($urandom);
      rl = $urandom_range(0, 15);
      rm = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
      for (int k = 0; k <= rl; k++) wbuf[k] = $urandom;
      do_write(ra, rl, rm, 1'b0);
      if ($urandom_range(0, 1) == 1) do_read(ra, rl);
      else do_read(AW'($urandom), $urandom_range(0, 8));
    end

    wait_ready();
    rd_n = 1'b0; addr = 21'h2_0105; data_len = 8'd25;
    @(negedge clk);
    rd_n = 1'b1;
    repeat (7) @(negedge clk);
    chk("midrst_valid_before", rd_valid, 1);
    rst = 1'b1;
    #1;
    chk("midrst_valid", rd_valid, 0);
    chk("midrst_busy", busy_n, 0);
    chk("midrst_data", data_out, 0);
    chk("midrst_init_done", init_done, 0);
    do_reset(1'b0);
    do_read(21'h2_0105, 25);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
